// File: rtl/rca_bist_reconfig.sv
// WIDTH-bit ripple-carry adder with one spare full adder.
// On-chip BIST locates a faulty adder and routes around it.
module rca_bist_reconfig #(
  parameter  int WIDTH = 4,
  localparam int FIW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_fail,
  output logic [FIW-1:0]   fault_idx,
  output logic [WIDTH:0]   fault_map,
  input  logic [WIDTH:0]   fault_inj
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_EVAL,
    S_DONE,
    S_FAIL
  } state_t;

  state_t state;
  logic [2:0] k;

  logic [WIDTH:0] fa_a, fa_b, fa_ci;
  logic [WIDTH:0] fa_s, fa_c;
  logic [WIDTH:0] a_lo, a_hi, b_lo, b_hi;
  logic [WIDTH:0] mism;
  logic [WIDTH-1:0] r_sum;
  logic r_cout;
  logic carry;
  logic exp_s, exp_c;
  logic multi;
  logic [FIW-1:0] low_idx;
  logic idle_like;

  assign a_lo = {1'b0, a};
  assign a_hi = {a, 1'b0};
  assign b_lo = {1'b0, b};
  assign b_hi = {b, 1'b0};

  // carry rides past the bypassed adder to the next used one
  always_comb begin
    fa_a  = '0;
    fa_b  = '0;
    fa_ci = '0;
    fa_s  = '0;
    fa_c  = '0;
    carry = cin;
    for (int p = 0; p <= WIDTH; p++) begin
      if (state == S_TEST) begin
        fa_a[p]  = k[2];
        fa_b[p]  = k[1];
        fa_ci[p] = k[0];
      end else if (FIW'(p) < fault_idx) begin
        fa_a[p]  = a_lo[p];
        fa_b[p]  = b_lo[p];
        fa_ci[p] = carry;
      end else if (FIW'(p) > fault_idx) begin
        fa_a[p]  = a_hi[p];
        fa_b[p]  = b_hi[p];
        fa_ci[p] = carry;
      end
      fa_s[p] = fa_a[p] ^ fa_b[p] ^ fa_ci[p] ^ fault_inj[p];
      fa_c[p] = ((fa_a[p] & fa_b[p]) | (fa_a[p] & fa_ci[p])
                | (fa_b[p] & fa_ci[p])) ^ fault_inj[p];
      if (FIW'(p) != fault_idx || state == S_TEST)
        carry = fa_c[p];
    end
  end

  always_comb begin
    r_sum = '0;
    for (int i = 0; i < WIDTH; i++)
      r_sum[i] = (FIW'(i) < fault_idx) ? fa_s[i] : fa_s[i+1];
    r_cout = (FIW'(WIDTH - 1) < fault_idx) ? fa_c[WIDTH-1] : fa_c[WIDTH];
  end

  assign exp_s = ^k;
  assign exp_c = (k[2] & k[1]) | (k[2] & k[0]) | (k[1] & k[0]);
  assign mism  = (fa_s ^ {(WIDTH+1){exp_s}})
               | (fa_c ^ {(WIDTH+1){exp_c}});

  assign multi = (fault_map & (fault_map - 1'b1)) != '0;

  always_comb begin
    low_idx = FIW'(WIDTH);
    for (int p = WIDTH; p >= 0; p--)
      if (fault_map[p]) low_idx = FIW'(p);
  end

  assign idle_like = (state == S_IDLE) || (state == S_DONE)
                   || (state == S_FAIL);
  assign in_ready  = idle_like && !bist_start;
  assign bist_busy = (state == S_TEST) || (state == S_EVAL);
  assign bist_done = (state == S_DONE);
  assign bist_fail = (state == S_FAIL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      fault_idx <= FIW'(WIDTH);
      fault_map <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_TEST: begin
          fault_map <= fault_map | mism;
          k         <= k + 3'd1;
          if (k == 3'd7) state <= S_EVAL;
        end
        S_EVAL: begin
          fault_idx <= low_idx;
          state     <= multi ? S_FAIL : S_DONE;
        end
        default: begin
          if (bist_start) begin
            state     <= S_TEST;
            fault_map <= '0;
            k         <= '0;
          end else if (in_valid) begin
            sum       <= r_sum;
            cout      <= r_cout;
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_bist_reconfig.sv
// Self-checking bench for rca_bist_reconfig: vector table,
// directed BIST sequences and randomized faults against a model.
module tb_rca_bist_reconfig;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         bist_start;
  logic         bist_busy, bist_done, bist_fail;
  logic [2:0]   fault_idx;
  logic [W:0]   fault_map;
  logic [W:0]   fault_inj;

  int checks = 0;
  int errors = 0;

  rca_bist_reconfig #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .cout(cout),
    .bist_start(bist_start), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail),
    .fault_idx(fault_idx), .fault_map(fault_map),
    .fault_inj(fault_inj)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_idx(input logic [W:0] inj);
    for (int i = 0; i <= W; i++)
      if (inj[i]) return i;
    return W;
  endfunction

  task automatic do_add(input string name, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk({name, "_ready"}, in_ready, 1);
    step();
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, {cout, sum}, int'(x) + int'(y) + int'(c));
  endtask

  task automatic bist_run(input string name, input logic [W:0] inj,
                          input bit pulse_mid);
    int cyc;
    fault_inj = inj;
    in_valid = 1'b0;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    cyc = 0;
    while (bist_busy && cyc < 30) begin
      chk({name, "_noready"}, in_ready, 0);
      cyc++;
      bist_start = pulse_mid && (cyc == 3);
      step();
    end
    bist_start = 1'b0;
    chk({name, "_busycyc"}, cyc, 9);
    chk({name, "_map"}, fault_map, inj);
    chk({name, "_idx"}, fault_idx, model_idx(inj));
    chk({name, "_done"}, bist_done, $countones(inj) <= 1);
    chk({name, "_fail"}, bist_fail, $countones(inj) > 1);
  endtask

  initial begin
    vecs[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vecs[1] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    vecs[4] = '{4'h8, 4'h8, 1'b1, 4'h1, 1'b1};
    vecs[5] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0};

    rst = 1'b1; in_valid = 1'b0; bist_start = 1'b0;
    a = '0; b = '0; cin = 1'b0; fault_inj = '0;
    step(); step();
    chk("rst_ready", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", bist_busy, 0);
    chk("rst_done", bist_done, 0);
    chk("rst_fail", bist_fail, 0);
    chk("rst_idx", fault_idx, W);
    chk("rst_map", fault_map, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      in_valid = 1'b1;
      step();
      chk("vec_valid", out_valid, 1);
      chk("vec_sum", sum, vecs[i].sum);
      chk("vec_cout", cout, vecs[i].cout);
    end
    in_valid = 1'b0;
    step();
    chk("idle_ovalid", out_valid, 0);

    bist_run("bist_b2", 5'b00100, 1'b0);
    chk("b2_idx_const", fault_idx, 2);
    do_add("b2_add", 4'h7, 4'h9, 1'b1);
    chk("b2_sum_const", sum, 4'h1);

    bist_run("bist_spare", 5'b10000, 1'b0);
    do_add("spare_add", 4'hA, 4'h5, 1'b0);

    bist_run("bist_two", 5'b00011, 1'b0);
    chk("fail_ready", in_ready, 1);

    bist_run("bist_midpulse", 5'b01000, 1'b0 | 1'b1);
    do_add("b3_add", 4'hC, 4'h6, 1'b1);

    a = 4'h1; b = 4'h2; cin = 1'b0;
    in_valid = 1'b1; bist_start = 1'b1;
    #1;
    chk("collide_ready", in_ready, 0);
    step();
    chk("collide_ovalid", out_valid, 0);
    chk("collide_busy", bist_busy, 1);
    in_valid = 1'b0; bist_start = 1'b0;
    for (int i = 0; i < 30 && bist_busy; i++) step();
    chk("collide_done", bist_done, 1);

    fault_inj = 5'b00100;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (4) step();
    chk("mid_busy", bist_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", bist_busy, 0);
    chk("mrst_map", fault_map, 0);
    chk("mrst_idx", fault_idx, W);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_done", bist_done, 0);

    for (int r = 0; r < 10; r++) begin
      logic [W:0] inj;
      int sel;
      sel = $urandom_range(0, 6);
      if (sel == 5) inj = '0;
      else if (sel == 6) inj = (W+1)'($urandom_range(1, 31));
      else inj = (W+1)'(1 << sel);
      bist_run("rnd_bist", inj, 1'b0);
      if ($countones(inj) <= 1) begin
        for (int j = 0; j < 8; j++)
          do_add("rnd_add", W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
